// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, drives the synchronous-read instruction
// memory address, and tags each word leaving the memory with its PC and a valid flag.
module pc_fetch #(
   parameter logic [4:0] RESET_PC = 5'd0,
   parameter logic [4:0] STEP     = 5'd4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       stall,
   input  logic       branch_taken,
   input  logic [4:0] branch_target,
   output logic [4:0] Address,
   output logic [4:0] fetch_pc,
   output logic       fetch_valid,
   output logic [7:0] fetch_count
);

   typedef enum logic [1:0] {
      BUBBLE = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [4:0] pc;
   logic [4:0] pc_nx;
   logic [4:0] fetch_pc_nx;
   logic [7:0] count_nx;
   logic       replay;
   logic       accept;

   // A word is on the memory output exactly when the last edge did not squash it.
   assign fetch_valid = (state != BUBBLE);
   assign replay      = stall && fetch_valid;
   assign accept      = fetch_valid && !stall && !branch_taken;

   always_comb begin
      // NOTE: every signal gets a default before the branches, so no path leaves one
      // unassigned and no latch is inferred.
      state_nx    = state;
      pc_nx       = pc;
      fetch_pc_nx = fetch_pc;
      count_nx    = fetch_count;
      Address     = pc;

      if (branch_taken) begin
         // Redirect beats stall; the word fetched from pc this edge is squashed.
         pc_nx    = branch_target;
         state_nx = BUBBLE;
      end else if (replay) begin
         // Re-issue the held word's address so the memory output stays stable.
         Address  = fetch_pc;
         state_nx = HOLD;
      end else begin
         fetch_pc_nx = pc;
         pc_nx       = pc + STEP;
         state_nx    = RUN;
         if (accept && fetch_count != 8'hFF) begin
            count_nx = fetch_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      if (reset) begin
         state       <= BUBBLE;
         pc          <= RESET_PC;
         fetch_pc    <= RESET_PC;
         fetch_count <= 8'd0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         fetch_pc    <= fetch_pc_nx;
         fetch_count <= count_nx;
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus randomized stall/redirect/reset traffic,
// checked every cycle against a transaction-level fetch model and a memory image.
module tb_pc_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [4:0]  branch_target;
   logic [4:0]  address;
   logic [4:0]  fetch_pc;
   logic        fetch_valid;
   logic [7:0]  fetch_count;
   logic [31:0] instruction;
   logic [31:0] mem [32];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_fetch #(.RESET_PC(5'd0), .STEP(5'd4)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .Address       (address),
      .fetch_pc      (fetch_pc),
      .fetch_valid   (fetch_valid),
      .fetch_count   (fetch_count)
   );

   // Synchronous-read instruction memory, one cycle latency.
   always @(posedge clk) instruction <= mem[address];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: the index of the next word to issue, the tag of the word
   // on the memory output, whether that word is live, and how many words were taken.
   int  m_next  = 0;
   int  m_tag   = 0;
   bit  m_valid = 1'b0;
   int  m_cnt   = 0;
   bit  armed   = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_next  = 0;
         m_tag   = 0;
         m_valid = 1'b0;
         m_cnt   = 0;
         armed   = 1'b1;
      end else if (branch_taken) begin
         m_next  = int'(branch_target);
         m_valid = 1'b0;
      end else if (!(stall && m_valid)) begin
         if (m_valid && m_cnt < 255) m_cnt = m_cnt + 1;
         m_tag   = m_next;
         m_next  = (m_next + 4) % 32;
         m_valid = 1'b1;
      end
   end

   always @(negedge clk) begin
      int exp_addr;
      if (armed) begin
         if (branch_taken)          exp_addr = m_next;
         else if (stall && m_valid) exp_addr = m_tag;
         else                       exp_addr = m_next;
         check("model_addr",  32'(address),     32'(exp_addr));
         check("model_valid", 32'(fetch_valid), 32'(m_valid));
         check("model_pc",    32'(fetch_pc),    32'(m_tag));
         check("model_count", 32'(fetch_count), 32'(m_cnt));
         if (m_valid) check("model_instr", instruction, mem[m_tag]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input logic [4:0] target);
      int n = 0;
      while (!(fetch_valid && fetch_pc == target) && n < 64) begin
         tick();
         n++;
      end
      check("reach_pc", 32'(fetch_pc), 32'(target));
   endtask

   initial begin
      logic [7:0]  c0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[4]  = 32'h00622020;
      mem[8]  = 32'hAC440000;
      mem[12] = 32'h8C450000;
      mem[16] = 32'h00623022;
      mem[20] = 32'h00623824;

      reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 5'd0;
      tick();
      tick();
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_count", 32'(fetch_count), 32'd0);
      check("rst_pc",    32'(fetch_pc),    32'd0);
      check("rst_addr",  32'(address),     32'd0);

      // Reset release: words 0..28 then the wrap back to 0.
      reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         check("seq_valid", 32'(fetch_valid), 32'd1);
         check("seq_pc",    32'(fetch_pc),    32'((i * 4) % 32));
         if (i == 2) check("seq_instr8", instruction, 32'hAC440000);
      end
      check("seq_count", 32'(fetch_count), 32'd8);

      // Stall while word 12 is on the output.
      run_until(5'd12);
      stall = 1'b1;
      #1;
      check("stall_addr0", 32'(address), 32'd12);
      c0 = fetch_count;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr",  32'(address),     32'd12);
         check("stall_pc",    32'(fetch_pc),    32'd12);
         check("stall_instr", instruction,      32'h8C450000);
         check("stall_count", 32'(fetch_count), 32'(c0));
         check("stall_valid", 32'(fetch_valid), 32'd1);
      end
      stall = 1'b0;
      tick();
      check("unstall_pc",    32'(fetch_pc), 32'd16);
      check("unstall_instr", instruction,   32'h00623022);

      // Redirect to 4 while word 16 is on the output.
      c0 = fetch_count;
      branch_taken = 1'b1; branch_target = 5'd4;
      tick();
      check("br_bubble", 32'(fetch_valid), 32'd0);
      branch_taken = 1'b0;
      tick();
      check("br_pc",    32'(fetch_pc),    32'd4);
      check("br_instr", instruction,      32'h00622020);
      check("br_valid", 32'(fetch_valid), 32'd1);
      check("br_count", 32'(fetch_count), 32'(c0));

      // Stall and redirect together: redirect wins.
      stall = 1'b1; branch_taken = 1'b1; branch_target = 5'd20;
      tick();
      check("sb_bubble", 32'(fetch_valid), 32'd0);
      stall = 1'b0; branch_taken = 1'b0;
      tick();
      check("sb_pc",    32'(fetch_pc), 32'd20);
      check("sb_instr", instruction,   32'h00623824);

      // Reset while holding.
      stall = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      check("hrst_valid", 32'(fetch_valid), 32'd0);
      check("hrst_count", 32'(fetch_count), 32'd0);
      reset = 1'b0; stall = 1'b0;
      tick();
      check("hrst_pc",    32'(fetch_pc),    32'd0);
      check("hrst_valid1", 32'(fetch_valid), 32'd1);

      // Saturation.
      repeat (320) tick();
      check("sat_count", 32'(fetch_count), 32'd255);

      // Randomized traffic, checked every cycle by the model.
      repeat (3000) begin
         reset         = ($urandom_range(99) == 0);
         stall         = ($urandom_range(99) < 30);
         branch_taken  = ($urandom_range(99) < 8);
         branch_target = 5'($urandom);
         tick();
      end
      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
